// File: rtl/rv23_pkg.sv
// Shared types and widths for the rv23 writeback path.
package rv23_pkg;

    localparam int ADDRESS_BITWIDTH = 5;
    localparam int DATA_WIDTH       = 32;
    localparam int NUM_REGS         = 2 ** ADDRESS_BITWIDTH;

    typedef struct packed {
        logic [ADDRESS_BITWIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]       wd;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rv23_wb_fifo.sv
// Small per-requester writeback FIFO; exposes per-slot valid/rd so the
// owner can build the in-flight register mask without extra state.
module rv23_wb_fifo
    import rv23_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic                                   push,
    input  logic                                   pop,
    input  wb_req_t                                din,
    output logic                                   full,
    output logic                                   empty,
    output wb_req_t                                head,
    output logic [DEPTH-1:0]                       ent_vld,
    output logic [DEPTH-1:0][ADDRESS_BITWIDTH-1:0] ent_rd
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t [DEPTH-1:0] mem;
    logic    [DEPTH-1:0] vld;
    logic    [PW-1:0]    wr_ptr;
    logic    [PW-1:0]    rd_ptr;

    // Per-slot valid bits make full/empty a single lookup; pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    assign full    = vld[wr_ptr];
    assign empty   = !vld[rd_ptr];
    assign head    = mem[rd_ptr];
    assign ent_vld = vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rd
        assign ent_rd[i] = mem[i].rd;
    end

endmodule

// File: rtl/rv23_wb_arbiter.sv
// Round-robin merge of ALU and LSU writebacks onto the single regfile write
// port, with a registered output stage and a per-register pending mask.
module rv23_wb_arbiter #(
    parameter int ADDRESS_BITWIDTH = rv23_pkg::ADDRESS_BITWIDTH,
    parameter int DATA_WIDTH       = rv23_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDRESS_BITWIDTH-1:0]   alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_wd,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [ADDRESS_BITWIDTH-1:0]   lsu_rd,
    input  logic [DATA_WIDTH-1:0]         lsu_wd,
    output logic                          rf_we,
    output logic [ADDRESS_BITWIDTH-1:0]   rf_rd,
    output logic [DATA_WIDTH-1:0]         rf_wd,
    output logic [2**ADDRESS_BITWIDTH-1:0] pending
);

    import rv23_pkg::*;

    localparam int NREG = 2 ** ADDRESS_BITWIDTH;

    wb_req_t alu_din, lsu_din, alu_head, lsu_head, win;
    logic    alu_full, alu_empty, lsu_full, lsu_empty;
    logic    alu_push, lsu_push, alu_pop, lsu_pop, pop;
    wb_src_e last_grant;

    logic [FIFO_DEPTH-1:0]                       alu_ent_vld, lsu_ent_vld;
    logic [FIFO_DEPTH-1:0][ADDRESS_BITWIDTH-1:0] alu_ent_rd, lsu_ent_rd;

    // Ready looks only at registered fullness, never at this cycle's pop.
    assign alu_ready = !alu_full && !flush;
    assign lsu_ready = !lsu_full && !flush;
    assign alu_push  = alu_valid && alu_ready;
    assign lsu_push  = lsu_valid && lsu_ready;
    assign alu_din   = '{rd: alu_rd, wd: alu_wd};
    assign lsu_din   = '{rd: lsu_rd, wd: lsu_wd};

    rv23_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (alu_push),
        .pop     (alu_pop),
        .din     (alu_din),
        .full    (alu_full),
        .empty   (alu_empty),
        .head    (alu_head),
        .ent_vld (alu_ent_vld),
        .ent_rd  (alu_ent_rd)
    );

    rv23_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (lsu_push),
        .pop     (lsu_pop),
        .din     (lsu_din),
        .full    (lsu_full),
        .empty   (lsu_empty),
        .head    (lsu_head),
        .ent_vld (lsu_ent_vld),
        .ent_rd  (lsu_ent_rd)
    );

    // On contention the side that did not win last time goes first.
    always_comb begin
        alu_pop = 1'b0;
        lsu_pop = 1'b0;
        if (!flush) begin
            if (!alu_empty && (lsu_empty || last_grant == WB_SRC_LSU))
                alu_pop = 1'b1;
            else if (!lsu_empty)
                lsu_pop = 1'b1;
        end
    end

    assign pop = alu_pop || lsu_pop;
    assign win = alu_pop ? alu_head : lsu_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wd      <= '0;
            last_grant <= WB_SRC_LSU;
        end else if (flush) begin
            rf_we <= 1'b0;
        end else if (pop) begin
            rf_we      <= (win.rd != '0);
            rf_rd      <= win.rd;
            rf_wd      <= win.wd;
            last_grant <= alu_pop ? WB_SRC_ALU : WB_SRC_LSU;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // x0 writes are consumed but never pending.
    always_comb begin
        pending = '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            if (alu_ent_vld[j]) pending[alu_ent_rd[j]] = 1'b1;
            if (lsu_ent_vld[j]) pending[lsu_ent_rd[j]] = 1'b1;
        end
        if (rf_we) pending[rf_rd] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule
